// File: rtl/tri_bbox_scanner.sv
// Latches a triangle, computes its screen-clipped bounding box and walks it in raster order,
// handing each point to the tester and streaming the verdicts to the pixel writer.
module tri_bbox_scanner #(
  parameter int XW    = 11,
  parameter int YW    = 10,
  parameter int X_LIM = 1279,
  parameter int Y_LIM = 1023,
  parameter int CNTW  = 22
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XW-1:0]   ax,
  input  logic [XW-1:0]   bx,
  input  logic [XW-1:0]   cx,
  input  logic [YW-1:0]   ay,
  input  logic [YW-1:0]   by,
  input  logic [YW-1:0]   cy,
  output logic [XW-1:0]   px,
  output logic [YW-1:0]   py,
  output logic            pt_req,
  input  logic            pt_done,
  input  logic            pt_inside,
  output logic            pix_valid,
  output logic [XW-1:0]   pix_x,
  output logic [YW-1:0]   pix_y,
  output logic            pix_in,
  output logic [CNTW-1:0] in_cnt,
  output logic            busy,
  output logic            done
);

  localparam logic [XW-1:0] XL = XW'(X_LIM);
  localparam logic [YW-1:0] YL = YW'(Y_LIM);

  typedef enum logic [2:0] {IDLE, BBOX, ISSUE, WAIT, EMIT, DONE} state_t;
  state_t state, state_nxt;

  logic [XW-1:0] va_x, vb_x, vc_x, xmin, xmax, xlo, xhi;
  logic [YW-1:0] va_y, vb_y, vc_y, ymin, ymax, ylo, yhi;
  logic          box_empty, last_pt;

  always_comb begin
    xlo = va_x;
    if (vb_x < xlo) xlo = vb_x;
    if (vc_x < xlo) xlo = vc_x;
    xhi = va_x;
    if (vb_x > xhi) xhi = vb_x;
    if (vc_x > xhi) xhi = vc_x;
    ylo = va_y;
    if (vb_y < ylo) ylo = vb_y;
    if (vc_y < ylo) ylo = vc_y;
    yhi = va_y;
    if (vb_y > yhi) yhi = vb_y;
    if (vc_y > yhi) yhi = vc_y;
  end

  assign box_empty = (xlo > XL) || (ylo > YL);
  // Test before increment so a box touching the top of the coordinate range never wraps.
  assign last_pt   = (px == xmax) && (py == ymax);
  assign pix_valid = (state == EMIT);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BBOX;
      BBOX:    state_nxt = box_empty ? DONE : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (pt_done) state_nxt = EMIT;
      EMIT:    state_nxt = last_pt ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      va_x <= '0; vb_x <= '0; vc_x <= '0;
      va_y <= '0; vb_y <= '0; vc_y <= '0;
      xmin <= '0; xmax <= '0; ymin <= '0; ymax <= '0;
      px <= '0; py <= '0; pt_req <= 1'b0;
      pix_x <= '0; pix_y <= '0; pix_in <= 1'b0;
      in_cnt <= '0; busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          va_x <= ax; vb_x <= bx; vc_x <= cx;
          va_y <= ay; vb_y <= by; vc_y <= cy;
          in_cnt <= '0;
          busy   <= 1'b1;
        end
        BBOX: begin
          xmin <= xlo;
          ymin <= ylo;
          xmax <= (xhi > XL) ? XL : xhi;
          ymax <= (yhi > YL) ? YL : yhi;
          px   <= xlo;
          py   <= ylo;
        end
        ISSUE: pt_req <= 1'b1;
        WAIT: if (pt_done) begin
          pt_req <= 1'b0;
          // An unknown verdict counts as outside.
          pix_in <= (pt_inside === 1'b1);
          pix_x  <= px;
          pix_y  <= py;
        end
        EMIT: begin
          if (pix_in && !(&in_cnt)) in_cnt <= in_cnt + CNTW'(1);
          if (!last_pt) begin
            if (px == xmax) begin
              px <= xmin;
              py <= py + YW'(1);
            end else begin
              px <= px + XW'(1);
            end
          end
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
